ball_physics: RTL and testbench

Per-frame ball motion and collision engine for the pong datapath. Once per frame, on `vSyncStart`, it advances the ball position, resolves wall and paddle bounces, and publishes `ballX`/`ballY`. The renderer consumes these positions. The game-state machine consumes the one-cycle collision pulses to detect scoring.

---
 rtl/ball_physics_if.sv | 27 ++
 rtl/ball_physics.sv | 156 +++++++++++++++
 tb/tb_ball_physics.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ball_physics_if.sv
// Ball engine bus: frame strobe, game state and paddle positions in;
// ball position and one-cycle collision pulses out.
interface ball_physics_if;
  logic        vSyncStart;
  logic [7:0]  gameState;
  logic [15:0] playerPaddleY;
  logic [15:0] computerPaddleY;
  logic [15:0] ballX;
  logic [15:0] ballY;
  logic        collisionBallScreenLeft;
  logic        collisionBallScreenRight;
  logic        collisionBallScreenTop;
  logic        collisionBallScreenBottom;
  logic        collisionBallPaddle;

  modport master (
    output vSyncStart, gameState, playerPaddleY, computerPaddleY,
    input  ballX, ballY, collisionBallScreenLeft, collisionBallScreenRight,
           collisionBallScreenTop, collisionBallScreenBottom, collisionBallPaddle
  );

  modport slave (
    input  vSyncStart, gameState, playerPaddleY, computerPaddleY,
    output ballX, ballY, collisionBallScreenLeft, collisionBallScreenRight,
           collisionBallScreenTop, collisionBallScreenBottom, collisionBallPaddle
  );
endinterface

// File: rtl/ball_physics.sv
// Per-frame ball motion: on each vSyncStart step the ball by SPEED on both
// axes, resolve paddle and wall bounces, publish the new position and pulse
// the collision flags for one cycle.
module ball_physics #(
  parameter int SCREEN_W          = 640,
  parameter int SCREEN_H          = 480,
  parameter int BALL_W            = 8,
  parameter int BALL_H            = 8,
  parameter int PADDLE_W          = 8,
  parameter int PADDLE_H          = 64,
  parameter int PLAYER_PADDLE_X   = 16,
  parameter int COMPUTER_PADDLE_X = 616,
  parameter int SPEED             = 4
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  ball_physics_if.slave  bus
);

  typedef enum logic [1:0] {HOLD, CALC, RESOLVE} state_t;

  // Signed 18-bit constants: one bit of headroom over the 17-bit candidates
  // so sums like nx+BALL_W never wrap.
  localparam logic signed [17:0] L_SW  = 18'(SCREEN_W);
  localparam logic signed [17:0] L_SH  = 18'(SCREEN_H);
  localparam logic signed [17:0] L_BW  = 18'(BALL_W);
  localparam logic signed [17:0] L_BH  = 18'(BALL_H);
  localparam logic signed [17:0] L_PW  = 18'(PADDLE_W);
  localparam logic signed [17:0] L_PH  = 18'(PADDLE_H);
  localparam logic signed [17:0] L_PPX = 18'(PLAYER_PADDLE_X);
  localparam logic signed [17:0] L_CPX = 18'(COMPUTER_PADDLE_X);
  localparam logic [16:0]        L_SPD = 17'(SPEED);

  localparam logic [15:0] L_X0    = 16'((SCREEN_W - BALL_W) / 2);
  localparam logic [15:0] L_Y0    = 16'((SCREEN_H - BALL_H) / 2);
  localparam logic [15:0] L_XPHIT = 16'(PLAYER_PADDLE_X + PADDLE_W);
  localparam logic [15:0] L_XCHIT = 16'(COMPUTER_PADDLE_X - BALL_W);
  localparam logic [15:0] L_XMAX  = 16'(SCREEN_W - BALL_W);
  localparam logic [15:0] L_YMAX  = 16'(SCREEN_H - BALL_H);

  state_t             r_state;
  logic [15:0]        r_x, r_y;
  logic               r_dx, r_dy;
  logic signed [16:0] r_nx, r_ny;
  logic [15:0]        r_pp_y, r_cp_y;
  logic               r_c_l, r_c_r, r_c_t, r_c_b, r_c_p;

  logic signed [17:0] w_nx, w_ny, w_ppy, w_cpy;
  logic               w_hit_p, w_hit_c, w_left, w_right, w_top, w_bot;

  assign w_nx  = {r_nx[16], r_nx};
  assign w_ny  = {r_ny[16], r_ny};
  assign w_ppy = {2'b00, r_pp_y};
  assign w_cpy = {2'b00, r_cp_y};

  // Paddles are only hittable while the ball travels toward them.
  assign w_hit_p = !r_dx && (w_nx < L_PPX + L_PW) && (w_nx + L_BW > L_PPX) &&
                   (w_ny + L_BH > w_ppy) && (w_ny < w_ppy + L_PH);
  assign w_hit_c =  r_dx && (w_nx < L_CPX + L_PW) && (w_nx + L_BW > L_CPX) &&
                   (w_ny + L_BH > w_cpy) && (w_ny < w_cpy + L_PH);
  assign w_left  = !w_hit_p && !w_hit_c && (w_nx < 18'sd0);
  assign w_right = !w_hit_p && !w_hit_c && (w_nx + L_BW > L_SW);
  assign w_top   = (w_ny < 18'sd0);
  assign w_bot   = (w_ny + L_BH > L_SH);

  assign bus.ballX                     = r_x;
  assign bus.ballY                     = r_y;
  assign bus.collisionBallScreenLeft   = r_c_l;
  assign bus.collisionBallScreenRight  = r_c_r;
  assign bus.collisionBallScreenTop    = r_c_t;
  assign bus.collisionBallScreenBottom = r_c_b;
  assign bus.collisionBallPaddle       = r_c_p;

  // Frame FSM: sample inputs on vSyncStart, compute candidates, commit.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= HOLD;
      r_x     <= L_X0;
      r_y     <= L_Y0;
      r_dx    <= 1'b1;
      r_dy    <= 1'b1;
      r_nx    <= '0;
      r_ny    <= '0;
      r_pp_y  <= '0;
      r_cp_y  <= '0;
      r_c_l   <= 1'b0;
      r_c_r   <= 1'b0;
      r_c_t   <= 1'b0;
      r_c_b   <= 1'b0;
      r_c_p   <= 1'b0;
    end else begin
      r_c_l <= 1'b0;
      r_c_r <= 1'b0;
      r_c_t <= 1'b0;
      r_c_b <= 1'b0;
      r_c_p <= 1'b0;
      case (r_state)
        HOLD: begin
          if (bus.vSyncStart) begin
            r_pp_y <= bus.playerPaddleY;
            r_cp_y <= bus.computerPaddleY;
            if (bus.gameState == 8'd1) begin
              r_state <= CALC;
            end else begin
              // Not playing: park the ball in the centre and latch the serve.
              r_x <= L_X0;
              r_y <= L_Y0;
              if (bus.gameState == 8'd2) r_dx <= 1'b1;
              else if (bus.gameState == 8'd3) r_dx <= 1'b0;
            end
          end
        end
        CALC: begin
          r_nx    <= r_dx ? ({1'b0, r_x} + L_SPD) : ({1'b0, r_x} - L_SPD);
          r_ny    <= r_dy ? ({1'b0, r_y} + L_SPD) : ({1'b0, r_y} - L_SPD);
          r_state <= RESOLVE;
        end
        RESOLVE: begin
          // X axis: paddles win over walls; wall exits keep dx (scoring).
          if (w_hit_p) begin
            r_x   <= L_XPHIT;
            r_dx  <= 1'b1;
            r_c_p <= 1'b1;
          end else if (w_hit_c) begin
            r_x   <= L_XCHIT;
            r_dx  <= 1'b0;
            r_c_p <= 1'b1;
          end else if (w_left) begin
            r_x   <= '0;
            r_c_l <= 1'b1;
          end else if (w_right) begin
            r_x   <= L_XMAX;
            r_c_r <= 1'b1;
          end else begin
            r_x <= w_nx[15:0];
          end
          // Y axis resolved independently so corners fire both.
          if (w_top) begin
            r_y   <= '0;
            r_dy  <= 1'b1;
            r_c_t <= 1'b1;
          end else if (w_bot) begin
            r_y   <= L_YMAX;
            r_dy  <= 1'b0;
            r_c_b <= 1'b1;
          end else begin
            r_y <= w_ny[15:0];
          end
          r_state <= HOLD;
        end
        default: r_state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics: ball trajectories from the centre with
// hand-computed positions at wall, paddle and corner frames.
module tb_ball_physics;
  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  ball_physics_if bus();

  ball_physics dut (.CLOCK_50(CLOCK_50), .resetn(resetn), .bus(bus));

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0, n_fail = 0;
  int c_l = 0, c_r = 0, c_t = 0, c_b = 0, c_p = 0;
  logic s_l, s_r, s_t, s_b, s_p;

  // Count pulse-high cycles, sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    if (bus.collisionBallScreenLeft)   c_l++;
    if (bus.collisionBallScreenRight)  c_r++;
    if (bus.collisionBallScreenTop)    c_t++;
    if (bus.collisionBallScreenBottom) c_b++;
    if (bus.collisionBallPaddle)       c_p++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int c_all();
    return c_l + c_r + c_t + c_b + c_p;
  endfunction

  // One frame: vSyncStart for a cycle, sample pulses in cycle T+3.
  task automatic frame();
    @(negedge CLOCK_50) bus.vSyncStart = 1'b1;
    @(negedge CLOCK_50) bus.vSyncStart = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    s_l = bus.collisionBallScreenLeft;
    s_r = bus.collisionBallScreenRight;
    s_t = bus.collisionBallScreenTop;
    s_b = bus.collisionBallScreenBottom;
    s_p = bus.collisionBallPaddle;
    @(negedge CLOCK_50);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  int base;

  initial begin
    bus.vSyncStart      = 1'b0;
    bus.gameState       = 8'd1;
    bus.playerPaddleY   = 16'd1000;
    bus.computerPaddleY = 16'd1000;
    #22;
    chk("rst_x", bus.ballX, 316);
    chk("rst_y", bus.ballY, 236);
    chk("rst_pulses", {bus.collisionBallScreenLeft, bus.collisionBallScreenRight,
        bus.collisionBallScreenTop, bus.collisionBallScreenBottom, bus.collisionBallPaddle}, 0);
    @(negedge CLOCK_50) resetn = 1'b1;

    // Latency: committed on the edge ending T+2.
    @(negedge CLOCK_50) bus.vSyncStart = 1'b1;
    @(negedge CLOCK_50) bus.vSyncStart = 1'b0;
    chk("lat_T0_x", bus.ballX, 316);
    @(negedge CLOCK_50);
    chk("lat_T1_x", bus.ballX, 316);
    @(negedge CLOCK_50);
    chk("lat_T2_x", bus.ballX, 320);
    chk("lat_T2_y", bus.ballY, 240);
    @(negedge CLOCK_50);
    run(2);
    chk("free_x", bus.ballX, 328);
    chk("free_y", bus.ballY, 248);
    chk("free_nopulse", c_all(), 0);

    // Left wall: serve left, 80 frames from centre.
    bus.gameState = 8'd3;
    base = c_all();
    frame();
    chk("srv3_x", bus.ballX, 316);
    chk("srv3_y", bus.ballY, 236);
    chk("srv3_nopulse", c_all() - base, 0);
    bus.gameState = 8'd1;
    run(79);
    chk("lw79_x", bus.ballX, 0);
    chk("lw79_y", bus.ballY, 396);
    chk("lw79_cnt", c_l, 0);
    chk("lw79_bot", c_b, 1);
    frame();
    chk("lw80_x", bus.ballX, 0);
    chk("lw80_y", bus.ballY, 392);
    chk("lw80_pulse", s_l, 1);
    chk("lw80_cnt", c_l, 1);
    frame();
    chk("lw81_dx_kept", bus.ballX, 0);
    chk("lw81_cnt", c_l, 2);

    // Serve right (dy=0 preserved), then corner right+bottom at frame 179.
    bus.gameState = 8'd2;
    base = c_all();
    frame();
    chk("srv2_x", bus.ballX, 316);
    chk("srv2_y", bus.ballY, 236);
    chk("srv2_nopulse", c_all() - base, 0);
    bus.gameState = 8'd1;
    c_r = 0; c_t = 0; c_b = 0;
    frame();
    chk("srv2_f1_x", bus.ballX, 320);
    chk("srv2_f1_y", bus.ballY, 232);
    run(177);
    chk("cn178_x", bus.ballX, 632);
    chk("cn178_y", bus.ballY, 472);
    chk("cn178_top", c_t, 1);
    chk("cn178_bot", c_b, 0);
    frame();
    chk("cn179_x", bus.ballX, 632);
    chk("cn179_y", bus.ballY, 472);
    chk("cn179_rb", {s_r, s_b, s_t, s_p, s_l}, 5'b11000);
    chk("cn179_rcnt", c_r, 100);
    frame();
    chk("cn180_y", bus.ballY, 468);

    // Player paddle bounce at frame 74 after a left serve.
    bus.gameState = 8'd3;
    frame();
    bus.gameState     = 8'd1;
    bus.playerPaddleY = 16'd30;
    c_t = 0; c_p = 0;
    run(73);
    chk("pd73_x", bus.ballX, 24);
    chk("pd73_y", bus.ballY, 52);
    chk("pd73_cnt", c_p, 0);
    frame();
    chk("pd74_x", bus.ballX, 24);
    chk("pd74_y", bus.ballY, 56);
    chk("pd74_pulse", s_p, 1);
    chk("pd74_top", c_t, 1);
    frame();
    chk("pd75_x", bus.ballX, 28);
    chk("pd75_y", bus.ballY, 60);
    chk("pd75_cnt", c_p, 1);

    // gameOver keeps dx; next play frame moves right and down.
    bus.gameState = 8'd0;
    base = c_all();
    frame();
    chk("go_x", bus.ballX, 316);
    chk("go_nopulse", c_all() - base, 0);
    bus.gameState = 8'd1;
    frame();
    chk("go_f1_x", bus.ballX, 320);
    chk("go_f1_y", bus.ballY, 240);

    // Reset dropped one cycle after vSyncStart aborts the update.
    base = c_all();
    @(negedge CLOCK_50) bus.vSyncStart = 1'b1;
    @(negedge CLOCK_50) bus.vSyncStart = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("arst_x", bus.ballX, 316);
    chk("arst_y", bus.ballY, 236);
    repeat (4) @(negedge CLOCK_50);
    chk("arst_nopulse", c_all() - base, 0);
    resetn = 1'b1;
    frame();
    chk("arst_f1_x", bus.ballX, 320);
    chk("arst_f1_y", bus.ballY, 240);

    // vSyncStart held through CALC/RESOLVE gives a single step.
    @(negedge CLOCK_50) bus.vSyncStart = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    bus.vSyncStart = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("vsig_x", bus.ballX, 324);
    chk("vsig_y", bus.ballY, 244);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
